seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder that follows on from the combinational full_adder cell. It adds two WIDTH-bit operands plus carry-in over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, through a registered carry. It uses valid/ready handshakes on input and output, so it can sit between streaming datapath stages where area matters more than throughput.

Parameters:
WIDTH, 32, operand and sum width in bits; must be an integer multiple of CHUNK.
CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK; CHUNK == WIDTH gives single-cycle operation.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out of bit WIDTH-1.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (asynchronous on rst_n low, effective immediately, including mid-operation):
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, ovf=0.
  - chunk index=0, carry register=0.
  - Any in-flight operation is discarded.
- Three states: IDLE, RUN, DONE.
- in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On in_valid && in_ready, latch a, b and cin; set carry register=cin and idx=0; go to RUN.
  - Otherwise remain in IDLE.
- RUN, on each edge:
  - Compute {c, s} = a[idx chunk] + b[idx chunk] + carry, where chunk idx is bits idx*CHUNK+CHUNK-1 down to idx*CHUNK.
  - Write s into that sum slice; carry <= c; idx <= idx+1.
  - On the edge with idx==NCHUNK-1: cout <= c, ovf <= (a[MSB]==b[MSB]) && (s[MSB-of-chunk]!=a[MSB]), and go to DONE.
  - in_valid is ignored throughout RUN.
- Latency: out_valid is high exactly NCHUNK edges after the accepting edge.
  - Example: WIDTH=32, CHUNK=8 gives 4 edges.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_ready=0, indefinitely.
  - On out_valid && out_ready, go to IDLE and clear out_valid.
  - sum, cout and ovf retain their last values; they are qualified only by out_valid.
- Simultaneous events: in_valid asserted in the same cycle as the DONE handshake is not accepted; acceptance occurs no earlier than the following cycle in IDLE.
- Maximum throughput: one result per NCHUNK+2 cycles.
- Partial sum bits are visible on sum during RUN; consumers must use only out_valid-qualified values.
- Width rules:
  - All chunk arithmetic is CHUNK+1 bits wide.
  - Carry-out of the final chunk is cout; no truncation error.
  - idx counter width = clog2(NCHUNK), minimum 1.

Optional Feature:
- Macro SEQ_CHUNK_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched together with the operands at acceptance.
  - When sub=1: b is inverted on latch, the carry register is initialised to 1 (cin ignored), and the result is a - b.
  - cout = NOT borrow, i.e. 1 when a >= b unsigned.
  - ovf computed on the inverted b.
  - When sub=0: behaviour is identical to the undefined build.
- Undefined: no sub port; add only.

Test Plan:
1. Reset with rst_n=0, then release -> in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
2. WIDTH=32, CHUNK=8; a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> out_valid high exactly 4 edges after acceptance, sum=0x00000000, cout=1, ovf=0; in_ready returns to 1 on the edge after the handshake.
3. a=0x7FFFFFFF, b=0, cin=1 -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1, ovf=1.
4. Backpressure: hold out_ready=0 for 6 cycles after out_valid, and drive a new in_valid with a=1, b=1 -> sum, cout and ovf stable and in_ready=0 for all 6 cycles; new operands are not accepted until after the handshake and IDLE.
5. Reset mid-RUN: pull rst_n low 2 edges after acceptance -> immediate out_valid=0, sum=0, in_ready=1; the next operation a=3, b=4 -> sum=7 with normal latency.
6. SEQ_CHUNK_ADDER_SUB_EN defined, a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; with CHUNK=32, a=9, b=4, sub=1 -> sum=5, cout=1, out_valid 1 edge after acceptance.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder that processes CHUNK bits per clock
// through a registered carry. Operands enter over a valid/ready handshake.
// Results leave over a second valid/ready handshake.
// NCHUNK = WIDTH/CHUNK edges separate acceptance from out_valid.
// Optional feature: define SEQ_CHUNK_ADDER_SUB_EN to add a 'sub' input
// that selects a - b (b inverted on latch, carry seeded with 1).
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;

  // Signed overflow: operands share a sign and the result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Select the active chunk and add it with the registered carry (CHUNK+1 wide).
  always_comb begin
    chunk_a   = a_r[idx*CHUNK +: CHUNK];
    chunk_b   = b_r[idx*CHUNK +: CHUNK];
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
  end

  // Operand capture at acceptance; qualified by the FSM, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b_eff;
    end
  end

  // Control FSM with registered result and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= cin_eff;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry                   <= chunk_sum[CHUNK];
          if (idx == LAST_IDX) begin
            cout      <= chunk_sum[CHUNK];
            ovf       <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], chunk_sum[CHUNK-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed testbench for seq_chunk_adder: a WIDTH=32/CHUNK=8 instance and a
// single-cycle WIDTH=32/CHUNK=32 instance. Subtract cases run only when
// SEQ_CHUNK_ADDER_SUB_EN is defined.
module tb_seq_chunk_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid0, in_ready0, cin0, out_valid0, out_ready0, cout0, ovf0;
  logic [31:0] a0, b0, sum0;
  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1;
  logic [31:0] a1, b1, sum1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic        sub0, sub1;
`endif

  int checks = 0;
  int errors = 0;
  int lat;
  logic [31:0] hold_sum;
  logic        hold_cout, hold_ovf;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub(sub0),
`endif
    .cin(cin0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub(sub1),
`endif
    .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands to dut0, complete the accepting edge, then count edges to out_valid.
  task automatic op0(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                     output int n);
    a0 = ta; b0 = tb; cin0 = tc; in_valid0 = 1'b1;
    chk("accept_ready0", in_ready0, 1'b1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Same for the single-cycle instance.
  task automatic op1(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                     output int n);
    a1 = ta; b1 = tb; cin1 = tc; in_valid1 = 1'b1;
    chk("accept_ready1", in_ready1, 1'b1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub0 = 1'b0; sub1 = 1'b0;
`endif

    // Reset state
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_sum", sum0, 32'h0);
    chk("rst_cout", cout0, 1'b0);
    chk("rst_ovf", ovf0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xFFFFFFFF + 1 wraps to zero with carry-out, 4-edge latency
    op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    chk("wrap_latency", lat, 4);
    chk("wrap_sum", sum0, 32'h0000_0000);
    chk("wrap_cout", cout0, 1'b1);
    chk("wrap_ovf", ovf0, 1'b0);
    chk("wrap_busy", in_ready0, 1'b0);
    @(posedge clk); #1;
    chk("wrap_hs_out_valid", out_valid0, 1'b0);
    chk("wrap_hs_in_ready", in_ready0, 1'b1);

    // Positive overflow via carry-in
    op0(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, lat);
    chk("posovf_latency", lat, 4);
    chk("posovf_sum", sum0, 32'h8000_0000);
    chk("posovf_cout", cout0, 1'b0);
    chk("posovf_ovf", ovf0, 1'b1);
    @(posedge clk); #1;

    // Negative overflow
    op0(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    chk("negovf_sum", sum0, 32'h0000_0000);
    chk("negovf_cout", cout0, 1'b1);
    chk("negovf_ovf", ovf0, 1'b1);
    @(posedge clk); #1;

    // Backpressure: result held 6 cycles while a new request waits
    out_ready0 = 1'b0;
    op0(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    chk("bp_latency", lat, 4);
    chk("bp_sum", sum0, 32'h2345_6789);
    chk("bp_cout", cout0, 1'b0);
    chk("bp_ovf", ovf0, 1'b0);
    hold_sum = sum0; hold_cout = cout0; hold_ovf = ovf0;
    a0 = 32'h1; b0 = 32'h1; cin0 = 1'b0; in_valid0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", sum0, hold_sum);
      chk("bp_hold_cout", cout0, hold_cout);
      chk("bp_hold_ovf", ovf0, hold_ovf);
      chk("bp_hold_valid", out_valid0, 1'b1);
      chk("bp_hold_in_ready", in_ready0, 1'b0);
    end
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_out_valid", out_valid0, 1'b0);
    chk("bp_hs_not_accepted", in_ready0, 1'b1);
    @(posedge clk); #1;
    chk("bp_next_accepted", in_ready0, 1'b0);
    in_valid0 = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_latency", lat, 4);
    chk("bp_next_sum", sum0, 32'h0000_0002);
    @(posedge clk); #1;

    // Reset two edges into RUN discards the operation immediately
    a0 = 32'h0101_0101; b0 = 32'h0101_0101; cin0 = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid0, 1'b0);
    chk("midrst_sum", sum0, 32'h0);
    chk("midrst_in_ready", in_ready0, 1'b1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op0(32'd3, 32'd4, 1'b0, lat);
    chk("postrst_latency", lat, 4);
    chk("postrst_sum", sum0, 32'd7);
    chk("postrst_cout", cout0, 1'b0);
    @(posedge clk); #1;

    // Single-cycle build
    op1(32'd9, 32'd4, 1'b0, lat);
    chk("single_latency", lat, 1);
    chk("single_sum", sum1, 32'd13);
    chk("single_cout", cout1, 1'b0);
    @(posedge clk); #1;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    // Subtraction: 5 - 7 borrows, 9 - 4 does not
    sub0 = 1'b1;
    op0(32'd5, 32'd7, 1'b0, lat);
    chk("sub_latency", lat, 4);
    chk("sub_sum", sum0, 32'hFFFF_FFFE);
    chk("sub_cout", cout0, 1'b0);
    chk("sub_ovf", ovf0, 1'b0);
    sub0 = 1'b0;
    @(posedge clk); #1;
    sub1 = 1'b1;
    op1(32'd9, 32'd4, 1'b0, lat);
    chk("sub1_latency", lat, 1);
    chk("sub1_sum", sum1, 32'd5);
    chk("sub1_cout", cout1, 1'b1);
    sub1 = 1'b0;
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
